// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for memory data port 2: pipeline side, programmer side and
// the registered command toward the byte-addressable memory.
//
// Handshake: a master raises *_REQ and holds REQ plus payload steady until
// the cycle in which its *_GNT is high; GNT is a one-cycle pulse meaning the
// command is on M_* that cycle. REQ may stay high after GNT to present the
// next command, which becomes eligible one edge later. Reads return one
// cycle after GNT with *_RVALID high and *_RDATA valid; RDATA is 0 otherwise.
interface dmem_port_arbiter_if;
    logic        P_REQ;
    logic        P_WE;
    logic [31:0] P_ADDR;
    logic [31:0] P_DIN;
    logic [1:0]  P_SIZE;
    logic        P_SIGN;
    logic        P_GNT;
    logic        P_STALL;
    logic        P_RVALID;
    logic [31:0] P_RDATA;

    logic        G_REQ;
    logic        G_WE;
    logic [31:0] G_ADDR;
    logic [31:0] G_DIN;
    logic        G_GNT;
    logic        G_RVALID;
    logic [31:0] G_RDATA;

    logic        M_READ;
    logic        M_WRITE;
    logic [31:0] M_ADDR;
    logic [31:0] M_DIN;
    logic [1:0]  M_SIZE;
    logic        M_SIGN;
    logic [31:0] M_DOUT;

    // Arbiter view
    modport slave (
        input  P_REQ, P_WE, P_ADDR, P_DIN, P_SIZE, P_SIGN,
        output P_GNT, P_STALL, P_RVALID, P_RDATA,
        input  G_REQ, G_WE, G_ADDR, G_DIN,
        output G_GNT, G_RVALID, G_RDATA,
        output M_READ, M_WRITE, M_ADDR, M_DIN, M_SIZE, M_SIGN,
        input  M_DOUT
    );

    // Environment view (requesters plus memory)
    modport master (
        output P_REQ, P_WE, P_ADDR, P_DIN, P_SIZE, P_SIGN,
        input  P_GNT, P_STALL, P_RVALID, P_RDATA,
        output G_REQ, G_WE, G_ADDR, G_DIN,
        input  G_GNT, G_RVALID, G_RDATA,
        input  M_READ, M_WRITE, M_ADDR, M_DIN, M_SIZE, M_SIGN,
        output M_DOUT
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbiter/sequencer for OTTER data memory port 2, shared by the pipeline
// memory stage and the UART programmer. One registered command per cycle,
// synchronous-read data returned the following cycle to its owner.
module dmem_port_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PROG_MODE,
    dmem_port_arbiter_if.slave bus,
    output logic [1:0]        o_dbg_owner,
    output logic [3:0]        o_dbg_wait
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_PROG = 2'd2
    } owner_e;

    localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

    owner_e      r_owner;
    owner_e      w_owner_nxt;
    owner_e      r_rd_owner;
    logic        r_rd_read;
    logic [3:0]  r_wait;

    logic        r_m_read;
    logic        r_m_write;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_din;
    logic [1:0]  r_m_size;
    logic        r_m_sign;

    logic        w_p_gnt;
    logic        w_g_gnt;
    logic        w_p_elig;
    logic        w_g_elig;
    logic        w_p_rvalid;
    logic        w_g_rvalid;

    // A master in its own grant cycle is not eligible, so the edge that ends
    // a grant never re-grants the same request.
    assign w_p_gnt  = (r_owner == OWN_PIPE);
    assign w_g_gnt  = (r_owner == OWN_PROG);
    assign w_p_elig = bus.P_REQ & ~w_p_gnt;
    assign w_g_elig = bus.G_REQ & ~w_g_gnt;

    // Owner state register: whose command sits on M_* this cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_owner <= OWN_NONE;
        else        r_owner <= w_owner_nxt;
    end

    // Winner selection: program mode first, then starvation override, then pipeline
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (PROG_MODE) begin
            if (w_g_elig) w_owner_nxt = OWN_PROG;
        end else if (w_g_elig && (r_wait >= LP_STARVE)) begin
            w_owner_nxt = OWN_PROG;
        end else if (w_p_elig) begin
            w_owner_nxt = OWN_PIPE;
        end else if (w_g_elig) begin
            w_owner_nxt = OWN_PROG;
        end
    end

    // Memory command register loaded from the winner; payload holds when idle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_m_addr  <= '0;
            r_m_din   <= '0;
            r_m_size  <= '0;
            r_m_sign  <= 1'b0;
        end else begin
            case (w_owner_nxt)
                OWN_PIPE: begin
                    r_m_read  <= ~bus.P_WE;
                    r_m_write <= bus.P_WE;
                    r_m_addr  <= bus.P_ADDR;
                    r_m_din   <= bus.P_DIN;
                    r_m_size  <= bus.P_SIZE;
                    r_m_sign  <= bus.P_SIGN;
                end
                OWN_PROG: begin
                    r_m_read  <= ~bus.G_WE;
                    r_m_write <= bus.G_WE;
                    r_m_addr  <= bus.G_ADDR;
                    r_m_din   <= bus.G_DIN;
                    r_m_size  <= 2'd2;
                    r_m_sign  <= 1'b0;
                end
                default: begin
                    r_m_read  <= 1'b0;
                    r_m_write <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts edges the programmer lost while eligible
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wait <= '0;
        end else if ((w_owner_nxt == OWN_PROG) || !bus.G_REQ) begin
            r_wait <= '0;
        end else if (w_g_elig && (r_wait != 4'hF)) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    // Read-return tracking: remembers who issued the read now on the bus
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_owner <= OWN_NONE;
            r_rd_read  <= 1'b0;
        end else begin
            r_rd_owner <= r_owner;
            r_rd_read  <= r_m_read;
        end
    end

    assign w_p_rvalid   = r_rd_read && (r_rd_owner == OWN_PIPE);
    assign w_g_rvalid   = r_rd_read && (r_rd_owner == OWN_PROG);

    assign bus.P_GNT    = w_p_gnt;
    assign bus.P_STALL  = bus.P_REQ & ~w_p_gnt;
    assign bus.P_RVALID = w_p_rvalid;
    assign bus.P_RDATA  = w_p_rvalid ? bus.M_DOUT : 32'd0;
    assign bus.G_GNT    = w_g_gnt;
    assign bus.G_RVALID = w_g_rvalid;
    assign bus.G_RDATA  = w_g_rvalid ? bus.M_DOUT : 32'd0;

    assign bus.M_READ   = r_m_read;
    assign bus.M_WRITE  = r_m_write;
    assign bus.M_ADDR   = r_m_addr;
    assign bus.M_DIN    = r_m_din;
    assign bus.M_SIZE   = r_m_size;
    assign bus.M_SIGN   = r_m_sign;

    assign o_dbg_owner  = r_owner;
    assign o_dbg_wait   = r_wait;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbiter and sequencer for data port 2 of the OTTER byte-addressable memory, shared between the pipeline memory stage and the UART programmer. It accepts held requests from both masters, issues at most one registered read or write per cycle to the memory, and returns synchronous-read data with a valid strobe. It stalls the pipeline while the port is busy and enforces programmer priority during program mode, with anti-starvation otherwise.

## Interface
- STARVE_MAX, 8: consecutive cycles a pending programmer request may lose to the pipeline before it is forced through (range 1–15)
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- PROG_MODE  in  1  programmer holds MCU in reset; programmer gets strict priority
- P_REQ  in  1  pipeline request; held with payload until P_GNT
- P_WE  in  1  1 = write, 0 = read
- P_ADDR  in  32  byte address
- P_DIN  in  32  write data
- P_SIZE  in  2  0 byte, 1 half, 2 word
- P_SIGN  in  1  0 = sign-extend, 1 = zero-extend (funct3[2])
- P_GNT  out  1  one-cycle pulse: pipeline command is on the memory bus this cycle
- P_STALL  out  1  P_REQ & ~P_GNT (combinational)
- P_RVALID  out  1  pipeline read data valid
- P_RDATA  out  32  pipeline read data; 0 when P_RVALID low
- G_REQ, G_WE  in  1  programmer request / write enable
- G_ADDR, G_DIN  in  32  programmer address / data; size forced to word, sign 0
- G_GNT, G_RVALID  out  1  programmer grant pulse / read valid
- G_RDATA  out  32  programmer read data; 0 when G_RVALID low
- M_READ, M_WRITE  out  1  registered memory strobes
- M_ADDR, M_DIN  out  32  registered address / write data
- M_SIZE  out  2  registered size
- M_SIGN  out  1  registered sign control
- M_DOUT  in  32  memory read data, valid the cycle after M_READ

## Operation
- State register OWNER ∈ {NONE, PIPE, PROG}: which master's command is on M_* this cycle. GNT outputs decode OWNER (P_GNT = OWNER==PIPE).
- Eligibility at each edge: a master is eligible if its REQ=1 and its GNT=0 in the current cycle (a request is never re-granted at the edge ending its own grant cycle; max one grant per master every 2 cycles).
- Selection at each edge, first match wins:
  - PROG_MODE=1: programmer if eligible; pipeline never selected.
  - Programmer eligible and WAIT ≥ STARVE_MAX: programmer.
  - Pipeline eligible: pipeline.
  - Programmer eligible: programmer.
  - Otherwise NONE.
- On selection, load M_* from the winner (programmer: M_SIZE=2, M_SIGN=0); M_READ=~WE, M_WRITE=WE. NONE: M_READ=M_WRITE=0, M_ADDR/M_DIN/M_SIZE/M_SIGN hold.
- WAIT (4-bit, saturating at 15): clears when programmer selected or G_REQ=0; increments each edge where programmer is eligible but not selected.
- Read return: RD_OWNER register loads {OWNER, M_READ} each edge; in the next cycle the matching RVALID=1 and RDATA=M_DOUT. Writes produce no RVALID.
- PROG_MODE change mid-flight: commands already on M_* complete; an outstanding pipeline read still returns P_RVALID.

## Timing
- Reset (RST_N low, async): OWNER=NONE, RD_OWNER cleared, WAIT=0; all GNT, RVALID, M_READ, M_WRITE = 0; RDATA = 0; M_ADDR, M_DIN = 0; M_SIZE = 0; M_SIGN = 0. In-flight reads are dropped (no RVALID after reset).
- Request sampled at edge E → GNT high and command on M_* in cycle E..E+1 → RVALID/RDATA in cycle E+1..E+2. Read latency from first REQ sample to data: 2 cycles uncontested.
- Back-to-back alternating masters: one command per cycle sustained.
- Simultaneous P_REQ and G_REQ, PROG_MODE=0, WAIT < STARVE_MAX: pipeline first; the programmer is granted no later than STARVE_MAX+1 edges after its request became eligible.
- Requester must keep REQ and payload stable until its GNT cycle ends; changing payload earlier is unsupported.

## Test plan
- Reset: assert RST_N=0 mid-read (M_READ=1) → all outputs 0 immediately; no RVALID after release.
- Uncontested pipeline read word @0x0000_0100, size 2 → P_GNT cycle 1, M_READ=1, M_ADDR=0x100; cycle 2 P_RVALID=1, P_RDATA=M_DOUT=0xDEADBEEF; P_STALL=1 only in cycle 0.
- Pipeline byte write 0x5A @0x0000_0203, size 0, sign 1 → M_WRITE=1, M_SIZE=0, M_SIGN=1, M_DIN=0x5A; no P_RVALID.
- PROG_MODE=1, both requesting continuously → only G_GNT pulses (every 2nd cycle, M_SIZE=2, M_SIGN=0); P_STALL stays 1; P_GNT never asserts.
- PROG_MODE=0, STARVE_MAX=3, pipeline and programmer requesting continuously → G_GNT observed within 4 edges of first eligibility; WAIT returns to 0 after grant.
- Pipeline read granted, PROG_MODE rises next cycle → P_RVALID still delivered with correct data; following grants go to programmer.
